audio_recorder: RTL and testbench
=================================

Name: audio_recorder

Overview:
Capture-side counterpart of the ROM playback path. It drains frames from Audio_Controller's ADC input FIFO through the read_audio_in / audio_in_available handshake. It mixes left and right to mono, decimates, and writes samples sequentially into a single-port sample RAM. It reports the recorded length so the playback path can replay exactly that many samples.

Parameters:
AUDIO_DATA_WIDTH, 32, width of the controller's left/right input channels
SAMPLE_WIDTH, 16, width of each stored RAM sample
ADDR_WIDTH, 18, RAM address width
RAM_SIZE, 156151, number of RAM words; recording stops when this many samples are written
DECIMATE, 8, store 1 of every DECIMATE captured frames (48 kHz -> 6 kHz)

Ports:
CLOCK_50  in  1  system clock; all logic on its rising edge
reset  in  1  asynchronous, active-high; clears all state
record_enable  in  1  level; high requests recording
audio_in_available  in  1  controller FIFO holds at least one frame
left_channel_audio_in  in  AUDIO_DATA_WIDTH  signed left sample, valid while audio_in_available
right_channel_audio_in  in  AUDIO_DATA_WIDTH  signed right sample, valid while audio_in_available
read_audio_in  out  1  one-cycle pop strobe to the controller
ram_wraddr  out  ADDR_WIDTH  RAM write address
ram_wrdata  out  SAMPLE_WIDTH  RAM write data
ram_wren  out  1  RAM write enable, one-cycle pulse
recording  out  1  high while in state REC
done  out  1  high while in state DONE
sample_count  out  ADDR_WIDTH+1  samples written in the current/last take

Behaviour:
- Reset values: read_audio_in=0, ram_wren=0, ram_wraddr=0, ram_wrdata=0, recording=0, done=0, sample_count=0. Internal state: FSM=IDLE, decim_cnt=0.
- Handshake (all states, including IDLE, so the FIFO never stalls):
  - In a cycle with audio_in_available=1 and read_audio_in=0, the frame is latched ("accept").
  - read_audio_in is registered high for exactly the next cycle.
  - It is never high two cycles in a row, so there is at most one pop per 2 cycles.
  - An accept happens only when audio_in_available is high.
- Mix: sign-extend both channels to AUDIO_DATA_WIDTH+1 bits, add, then arithmetic shift right by 1. The sample is bits [AUDIO_DATA_WIDTH-1 : AUDIO_DATA_WIDTH-SAMPLE_WIDTH] of the result, i.e. truncation with no rounding. Overflow is impossible.
- FSM states: IDLE, REC, DONE.
  - IDLE:
    - record_enable=1 -> REC.
    - On entry to REC: ram_wraddr=0, sample_count=0, decim_cnt=0.
  - REC, on each accept:
    - If decim_cnt==0, the mixed sample is a "keep".
    - decim_cnt increments and wraps from DECIMATE-1 to 0.
    - A keep accepted at cycle t gives ram_wren=1 at t+1 with ram_wraddr=sample_count and ram_wrdata=mixed sample. sample_count increments at that same edge.
  - REC exits:
    - After the write that makes sample_count==RAM_SIZE -> DONE.
    - record_enable=0 -> DONE. A write already scheduled for the next cycle still completes; no new accept is kept.
    - If both exit conditions occur in the same cycle, the result is the same: DONE.
  - DONE:
    - done=1; sample_count holds.
    - Accepts continue and are discarded; ram_wren stays 0.
    - record_enable=0 -> IDLE. done then drops, sample_count holds.
    - If record_enable stays high in DONE, no new take starts until it is deasserted and reasserted.
- recording=1 exactly while in REC. ram_wren is never high outside REC, except for the single trailing write described above.
- An asynchronous reset mid-take aborts immediately to the reset values. RAM contents are not cleared.
- DECIMATE=1 stores every frame. Address never exceeds RAM_SIZE-1.

Test Plan:
1. DECIMATE=1, RAM_SIZE=4, record_enable=1, feed 4 frames L=R=32'h40000000 -> four ram_wren pulses, addrs 0..3, data 16'h4000 each, then done=1, sample_count=4.
2. Mix/sign check: L=32'h7FFFFFFF, R=32'h80000000 -> ram_wrdata=16'hFFFF. L=R=32'h80000000 -> 16'h8000.
3. DECIMATE=8, 24 frames while in REC -> exactly 3 writes, from frames 0, 8 and 16.
4. audio_in_available held high for 10 cycles -> read_audio_in pulses in alternate cycles (5 pops), each preceded by an accept.
5. Drop record_enable in the same cycle as a keep accept -> that write still occurs, then DONE with sample_count including it; no further writes. Raise again -> new take from address 0.
6. Assert reset mid-take (sample_count=2, write pending) -> all outputs zero asynchronously, no write, FSM IDLE. After release, frames are accepted but not written until record_enable.

Source files
------------

// File: rtl/audio_recorder.sv
// audio_recorder: capture path from the audio controller's ADC FIFO into a
// single-port sample RAM.
//
// The block pops frames from the controller, averages left and right into one
// mono sample, and keeps 1 of every DECIMATE frames. Each kept sample is
// written to the next RAM address. sample_count reports the recorded length,
// so the playback path can replay exactly that many samples.
//
// Ports:
//   CLOCK_50               system clock, rising edge
//   reset                  asynchronous, active-high; clears all state
//   record_enable          level request to record
//   audio_in_available     controller FIFO holds at least one frame
//   left_channel_audio_in  signed left sample
//   right_channel_audio_in signed right sample
//   read_audio_in          one-cycle pop strobe to the controller
//   ram_wraddr             RAM write address
//   ram_wrdata             RAM write data (mono, truncated)
//   ram_wren               RAM write enable, one-cycle pulse
//   recording              high while in REC
//   done                   high while in DONE
//   sample_count           samples written in the current/last take
module audio_recorder #(
  parameter int unsigned AUDIO_DATA_WIDTH = 32,
  parameter int unsigned SAMPLE_WIDTH     = 16,
  parameter int unsigned ADDR_WIDTH       = 18,
  parameter int unsigned RAM_SIZE         = 156151,
  parameter int unsigned DECIMATE         = 8
) (
  input  logic                        CLOCK_50,
  input  logic                        reset,
  input  logic                        record_enable,
  input  logic                        audio_in_available,
  input  logic [AUDIO_DATA_WIDTH-1:0] left_channel_audio_in,
  input  logic [AUDIO_DATA_WIDTH-1:0] right_channel_audio_in,
  output logic                        read_audio_in,
  output logic [ADDR_WIDTH-1:0]       ram_wraddr,
  output logic [SAMPLE_WIDTH-1:0]     ram_wrdata,
  output logic                        ram_wren,
  output logic                        recording,
  output logic                        done,
  output logic [ADDR_WIDTH:0]         sample_count
);

  localparam int unsigned DW = (DECIMATE > 1) ? $clog2(DECIMATE) : 1;
  localparam int unsigned CW = ADDR_WIDTH + 1;
  localparam int unsigned SW = AUDIO_DATA_WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  state_t            next_state;
  logic [DW-1:0]     decim_cnt;

  logic              accept_c;
  logic              keep_c;
  logic              full_c;
  logic              start_c;
  logic [SW-1:0]     sum_c;
  logic [SAMPLE_WIDTH-1:0] mixed_c;

  // A frame is taken whenever one is offered and we did not pop last cycle,
  // in every state, so the controller FIFO keeps draining.
  assign accept_c = audio_in_available && !read_audio_in;

  // Take is full once RAM_SIZE samples are written; no address past RAM_SIZE-1.
  assign full_c = (sample_count >= CW'(RAM_SIZE));

  // Only the first frame of each decimation group is stored. Independent of
  // record_enable, so a keep accepted as recording stops still gets written.
  assign keep_c = accept_c && (state == REC) && (decim_cnt == '0) && !full_c;

  assign start_c = (state == IDLE) && (next_state == REC);

  // Sign-extended sum, then >>>1 and take the top SAMPLE_WIDTH bits of the
  // average; together that is the top SAMPLE_WIDTH bits of the sum.
  assign sum_c   = {left_channel_audio_in[AUDIO_DATA_WIDTH-1], left_channel_audio_in}
                 + {right_channel_audio_in[AUDIO_DATA_WIDTH-1], right_channel_audio_in};
  assign mixed_c = SAMPLE_WIDTH'(sum_c >> (SW - SAMPLE_WIDTH));

  // State register.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (record_enable) begin
          next_state = REC;
        end
      end
      REC: begin
        if (!record_enable || full_c) begin
          next_state = DONE;
        end
      end
      DONE: begin
        if (!record_enable) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Handshake, status flags and RAM write datapath.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      read_audio_in <= 1'b0;
      ram_wren      <= 1'b0;
      ram_wraddr    <= '0;
      ram_wrdata    <= '0;
      recording     <= 1'b0;
      done          <= 1'b0;
      sample_count  <= '0;
      decim_cnt     <= '0;
    end else begin
      read_audio_in <= accept_c;
      ram_wren      <= keep_c;
      recording     <= (next_state == REC);
      done          <= (next_state == DONE);

      if (start_c) begin
        ram_wraddr   <= '0;
        sample_count <= '0;
        decim_cnt    <= '0;
      end else begin
        if ((state == REC) && accept_c) begin
          if (decim_cnt == DW'(DECIMATE - 1)) begin
            decim_cnt <= '0;
          end else begin
            decim_cnt <= decim_cnt + DW'(1);
          end
        end
        if (keep_c) begin
          ram_wraddr   <= ADDR_WIDTH'(sample_count);
          ram_wrdata   <= mixed_c;
          sample_count <= sample_count + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_audio_recorder.sv
// Testbench for audio_recorder. Two instances share clock, reset and the
// frame source: dut1 (DECIMATE=1, RAM_SIZE=4) and dut8 (DECIMATE=8).
// Expected RAM writes are queued when frames are driven and popped by a
// monitor whenever a DUT pulses ram_wren.
module tb_audio_recorder;

  typedef struct packed {
    logic [17:0] addr;
    logic [15:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        avail;
  logic [31:0] l_in;
  logic [31:0] r_in;
  logic        rec1, rec8;

  logic        rd1, wren1, recording1, done1;
  logic [17:0] addr1;
  logic [15:0] data1;
  logic [18:0] cnt1;
  logic        rd8, wren8, recording8, done8;
  logic [17:0] addr8;
  logic [15:0] data8;
  logic [18:0] cnt8;

  int checks   = 0;
  int failures = 0;
  wr_t q1[$];
  wr_t q8[$];

  always #5 clk = ~clk;

  audio_recorder #(.DECIMATE(1), .RAM_SIZE(4)) dut1 (
    .CLOCK_50(clk), .reset(reset), .record_enable(rec1),
    .audio_in_available(avail), .left_channel_audio_in(l_in),
    .right_channel_audio_in(r_in), .read_audio_in(rd1),
    .ram_wraddr(addr1), .ram_wrdata(data1), .ram_wren(wren1),
    .recording(recording1), .done(done1), .sample_count(cnt1)
  );

  audio_recorder #(.DECIMATE(8)) dut8 (
    .CLOCK_50(clk), .reset(reset), .record_enable(rec8),
    .audio_in_available(avail), .left_channel_audio_in(l_in),
    .right_channel_audio_in(r_in), .read_audio_in(rd8),
    .ram_wraddr(addr8), .ram_wrdata(data8), .ram_wren(wren8),
    .recording(recording8), .done(done8), .sample_count(cnt8)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference mono mix: average of sign-extended channels, top 16 bits.
  function automatic logic [15:0] mix(input logic [31:0] l, input logic [31:0] r);
    logic [32:0] s;
    logic [32:0] avg;
    s   = {l[31], l} + {r[31], r};
    avg = {s[32], s[32:1]};
    return avg[31:16];
  endfunction

  // Offer one frame for one cycle; both DUTs must pop it.
  task automatic send(input logic [31:0] l, input logic [31:0] r);
    @(negedge clk);
    avail = 1'b1;
    l_in  = l;
    r_in  = r;
    @(negedge clk);
    avail = 1'b0;
    chk("pop1", 64'(rd1), 64'd1);
    chk("pop8", 64'(rd8), 64'd1);
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Scoreboard: every write must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!reset) begin
      if (wren1) begin
        if (q1.size() == 0) begin
          chk("dut1_unexpected_write", 64'(addr1), 64'h3FFFF_FFFF);
        end else begin
          wr_t e;
          e = q1.pop_front();
          chk("dut1_wraddr", 64'(addr1), 64'(e.addr));
          chk("dut1_wrdata", 64'(data1), 64'(e.data));
        end
      end
      if (wren8) begin
        if (q8.size() == 0) begin
          chk("dut8_unexpected_write", 64'(addr8), 64'h3FFFF_FFFF);
        end else begin
          wr_t e;
          e = q8.pop_front();
          chk("dut8_wraddr", 64'(addr8), 64'(e.addr));
          chk("dut8_wrdata", 64'(data8), 64'(e.data));
        end
      end
    end
  end

  initial begin
    logic [31:0] lv, rv;
    int pops;
    reset = 1'b1;
    avail = 1'b0;
    l_in  = '0;
    r_in  = '0;
    rec1  = 1'b0;
    rec8  = 1'b0;

    // Reset state
    wait_cycles(3);
    chk("rst_read",      64'(rd1),        64'd0);
    chk("rst_wren",      64'(wren1),      64'd0);
    chk("rst_wraddr",    64'(addr1),      64'd0);
    chk("rst_wrdata",    64'(data1),      64'd0);
    chk("rst_recording", 64'(recording1), 64'd0);
    chk("rst_done",      64'(done1),      64'd0);
    chk("rst_count",     64'(cnt1),       64'd0);
    reset = 1'b0;

    // Four frames fill a RAM_SIZE=4 take, then DONE
    wait_cycles(1);
    rec1 = 1'b1;
    wait_cycles(1);
    chk("t1_recording", 64'(recording1), 64'd1);
    for (int i = 0; i < 4; i++) begin
      q1.push_back('{addr: 18'(i), data: 16'h4000});
      send(32'h4000_0000, 32'h4000_0000);
    end
    wait_cycles(3);
    chk("t1_done",      64'(done1),      64'd1);
    chk("t1_recording", 64'(recording1), 64'd0);
    chk("t1_count",     64'(cnt1),       64'd4);
    // DONE with record_enable still high: frames popped, nothing written
    send(32'h1234_0000, 32'h1234_0000);
    wait_cycles(2);
    chk("t1_done_hold",  64'(done1), 64'd1);
    chk("t1_count_hold", 64'(cnt1),  64'd4);

    // Mix sign/truncation corner cases
    rec1 = 1'b0;
    wait_cycles(2);
    chk("t2_done_drop", 64'(done1), 64'd0);
    chk("t2_count_keep", 64'(cnt1), 64'd4);
    rec1 = 1'b1;
    wait_cycles(1);
    chk("t2_count_clr", 64'(cnt1), 64'd0);
    q1.push_back('{addr: 18'd0, data: 16'hFFFF});
    send(32'h7FFF_FFFF, 32'h8000_0000);
    q1.push_back('{addr: 18'd1, data: 16'h8000});
    send(32'h8000_0000, 32'h8000_0000);
    wait_cycles(1);
    rec1 = 1'b0;
    wait_cycles(2);
    chk("t2_idle_done", 64'(done1), 64'd0);
    chk("t2_count",     64'(cnt1),  64'd2);

    // Decimate by 8: 24 frames keep frames 0, 8, 16
    rec8 = 1'b1;
    wait_cycles(1);
    for (int i = 0; i < 24; i++) begin
      lv = {8'(i * 37 + 5), 24'h00_0F00};
      rv = {8'(8'hF0 - 8'(i * 11)), 24'h12_3456};
      if (i % 8 == 0) q8.push_back('{addr: 18'(i / 8), data: mix(lv, rv)});
      send(lv, rv);
    end
    wait_cycles(2);
    chk("t3_count", 64'(cnt8), 64'd3);
    rec8 = 1'b0;
    wait_cycles(1);
    chk("t3_done", 64'(done8), 64'd1);
    wait_cycles(2);
    chk("t3_idle", 64'(done8), 64'd0);
    chk("t3_count_keep", 64'(cnt8), 64'd3);

    // Continuous availability: pops on alternate cycles
    pops = 0;
    @(negedge clk);
    avail = 1'b1;
    l_in  = 32'h0101_0101;
    r_in  = 32'h0202_0202;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      chk("t4_read1", 64'(rd1), 64'(k % 2));
      chk("t4_read8", 64'(rd8), 64'(k % 2));
      if (rd1) pops++;
    end
    avail = 1'b0;
    chk("t4_pops", 64'(pops), 64'd5);

    // record_enable drops in the same cycle as a keep accept
    rec1 = 1'b1;
    wait_cycles(1);
    q1.push_back('{addr: 18'd0, data: mix(32'h1000_0000, 32'h3000_0000)});
    send(32'h1000_0000, 32'h3000_0000);
    @(negedge clk);
    avail = 1'b1;
    l_in  = 32'hF000_0000;
    r_in  = 32'h0800_0000;
    rec1  = 1'b0;
    q1.push_back('{addr: 18'd1, data: mix(32'hF000_0000, 32'h0800_0000)});
    @(negedge clk);
    avail = 1'b0;
    chk("t5_trailing_wren", 64'(wren1), 64'd1);
    chk("t5_done",          64'(done1), 64'd1);
    chk("t5_count",         64'(cnt1),  64'd2);
    wait_cycles(1);
    chk("t5_idle", 64'(done1), 64'd0);
    send(32'h5555_0000, 32'h5555_0000);
    wait_cycles(2);
    chk("t5_count_hold", 64'(cnt1), 64'd2);
    // New take restarts at address 0
    rec1 = 1'b1;
    wait_cycles(1);
    chk("t5_new_take", 64'(cnt1), 64'd0);
    q1.push_back('{addr: 18'd0, data: mix(32'h2222_0000, 32'h4444_0000)});
    send(32'h2222_0000, 32'h4444_0000);
    q1.push_back('{addr: 18'd1, data: mix(32'h9000_0000, 32'hA000_0000)});
    send(32'h9000_0000, 32'hA000_0000);
    wait_cycles(1);
    chk("t6_pre_count", 64'(cnt1), 64'd2);

    // Asynchronous reset with a frame about to be accepted
    @(negedge clk);
    avail = 1'b1;
    l_in  = 32'h7777_0000;
    r_in  = 32'h7777_0000;
    #2;
    reset = 1'b1;
    avail = 1'b0;
    #1;
    chk("t6_wraddr",    64'(addr1),      64'd0);
    chk("t6_wrdata",    64'(data1),      64'd0);
    chk("t6_wren",      64'(wren1),      64'd0);
    chk("t6_recording", 64'(recording1), 64'd0);
    chk("t6_count",     64'(cnt1),       64'd0);
    wait_cycles(2);
    reset = 1'b0;
    rec1  = 1'b0;
    send(32'h3333_0000, 32'h3333_0000);
    send(32'h4444_0000, 32'h4444_0000);
    wait_cycles(1);
    chk("t6_idle_count", 64'(cnt1),       64'd0);
    chk("t6_idle_rec",   64'(recording1), 64'd0);
    rec1 = 1'b1;
    wait_cycles(1);
    q1.push_back('{addr: 18'd0, data: mix(32'h0ABC_0000, 32'hF123_0000)});
    send(32'h0ABC_0000, 32'hF123_0000);
    wait_cycles(2);
    chk("t6_after_count", 64'(cnt1), 64'd1);
    rec1 = 1'b0;
    wait_cycles(3);

    chk("q1_drained", 64'(q1.size()), 64'd0);
    chk("q8_drained", 64'(q8.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
